alu_cmd_issue: RTL and testbench

- Command-issue stage directly upstream of the 6-bit combinational ALU.
- Accepts {control, A, B, fwd} commands over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Drives the FIFO head onto the ALU operand/control lines, then captures the ALU's out/carry/zero into a result register that has its own valid/ready handshake.
- Holds an accumulator (the last captured result) that can replace operand A, so ALU ops can be chained.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_cmd_fifo.sv | 56 +++++
 rtl/alu_cmd_issue.sv | 119 +++++++++++
 tb/tb_alu_cmd_issue.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU constants, control codes and command-entry helpers.
// Command entries are packed MSB-first as {fwd, ctrl, a, b}.
package alu_pkg;

    localparam int DEF_WIDTH = 6;
    localparam int CTRL_W    = 4;

    localparam logic [CTRL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [CTRL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [CTRL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [CTRL_W-1:0] ALU_SLL = 4'b0011;
    localparam logic [CTRL_W-1:0] ALU_XOR = 4'b0100;
    localparam logic [CTRL_W-1:0] ALU_SRL = 4'b0101;
    localparam logic [CTRL_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [CTRL_W-1:0] ALU_SRA = 4'b0111;
    localparam logic [CTRL_W-1:0] ALU_SLT = 4'b1000;

    function automatic logic is_legal_ctrl(input logic [CTRL_W-1:0] c);
        logic ok;
        ok = 1'b0;
        case (c)
            ALU_AND, ALU_OR, ALU_ADD,
            ALU_SLL, ALU_XOR, ALU_SRL,
            ALU_SUB, ALU_SRA, ALU_SLT: ok = 1'b1;
            default:                   ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic int cmd_bits(input int w);
        return 2 * w + CTRL_W + 1;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO with extra-MSB pointers for full/empty detection.
// Push is ignored when full and pop when empty.
module alu_cmd_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wptr_q, wptr_d;
    logic [AW:0]  rptr_q, rptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/alu_cmd_issue.sv
// Command-issue stage in front of the combinational ALU: queues commands,
// drives the head onto the ALU and captures its result with forwarding.
import alu_pkg::*;

module alu_cmd_issue #(
    parameter int WIDTH = alu_pkg::DEF_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_ctrl,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_fwd,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    input  logic             alu_zero,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_carry,
    output logic             res_zero,
    output logic             res_illegal,
    output logic [WIDTH-1:0] acc
);

    localparam int CW = cmd_bits(WIDTH);

    logic [CW-1:0]    wr_e, hd_e;
    logic             full, empty, issue;
    logic             hd_fwd;
    logic [3:0]       hd_ctrl;
    logic [WIDTH-1:0] hd_a, hd_b;

    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_carry_q, res_carry_d;
    logic             res_zero_q, res_zero_d;
    logic             res_illegal_q, res_illegal_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    assign wr_e      = {cmd_fwd, cmd_ctrl, cmd_a, cmd_b};
    assign cmd_ready = !full;
    assign issue     = !empty && (!res_valid_q || res_ready);

    alu_cmd_fifo #(
        .W     (CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (cmd_valid && !full),
        .pop_i   (issue),
        .wdata_i (wr_e),
        .rdata_o (hd_e),
        .full_o  (full),
        .empty_o (empty)
    );

    assign hd_fwd  = hd_e[CW-1];
    assign hd_ctrl = hd_e[CW-2 -: 4];
    assign hd_a    = hd_e[2*WIDTH-1 -: WIDTH];
    assign hd_b    = hd_e[WIDTH-1:0];

    // An empty FIFO parks the ALU inputs at zero rather than stale data.
    assign alu_ctrl = empty ? '0 : hd_ctrl;
    assign alu_a    = empty ? '0 : (hd_fwd ? acc_q : hd_a);
    assign alu_b    = empty ? '0 : hd_b;

    always_comb begin
        res_valid_d   = res_valid_q;
        res_data_d    = res_data_q;
        res_carry_d   = res_carry_q;
        res_zero_d    = res_zero_q;
        res_illegal_d = res_illegal_q;
        acc_d         = acc_q;
        if (issue) begin
            res_valid_d   = 1'b1;
            res_data_d    = alu_out;
            res_carry_d   = alu_carry;
            res_zero_d    = alu_zero;
            res_illegal_d = !is_legal_ctrl(hd_ctrl);
            acc_d         = alu_out;
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_carry_q   <= 1'b0;
            res_zero_q    <= 1'b0;
            res_illegal_q <= 1'b0;
            acc_q         <= '0;
        end else begin
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            res_carry_q   <= res_carry_d;
            res_zero_q    <= res_zero_d;
            res_illegal_q <= res_illegal_d;
            acc_q         <= acc_d;
        end
    end

    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_carry   = res_carry_q;
    assign res_zero    = res_zero_q;
    assign res_illegal = res_illegal_q;
    assign acc         = acc_q;

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Bench for alu_cmd_issue: a behavioural ALU, an in-order result
// reference with a modelled accumulator, directed and random steps.
module tb_alu_cmd_issue;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_fwd;
    logic [3:0] cmd_ctrl, alu_ctrl;
    logic [5:0] cmd_a, cmd_b, alu_a, alu_b, alu_out;
    logic       alu_carry, alu_zero;
    logic       res_valid, res_ready, res_carry, res_zero, res_illegal;
    logic [5:0] res_data, acc;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] c;
        logic [5:0] a;
        logic [5:0] b;
        logic       f;
    } cmd_s;

    cmd_s       q[$];
    logic [5:0] macc;

    always #5 clk = ~clk;

    alu_cmd_issue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_ctrl    (cmd_ctrl),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_fwd     (cmd_fwd),
        .alu_ctrl    (alu_ctrl),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_out     (alu_out),
        .alu_carry   (alu_carry),
        .alu_zero    (alu_zero),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_carry   (res_carry),
        .res_zero    (res_zero),
        .res_illegal (res_illegal),
        .acc         (acc)
    );

    // Carry on SUB is the borrow (a < b unsigned).
    function automatic void alu_fn(input logic [3:0] c, input logic [5:0] a,
                                   input logic [5:0] b, output logic [5:0] o,
                                   output logic cy, output logic z);
        logic [6:0] t;
        o  = 6'd0;
        cy = 1'b0;
        case (c)
            4'd0: o = a & b;
            4'd1: o = a | b;
            4'd2: begin t = {1'b0, a} + {1'b0, b}; o = t[5:0]; cy = t[6]; end
            4'd3: o = a << b;
            4'd4: o = a ^ b;
            4'd5: o = a >> b;
            4'd6: begin t = {1'b0, a} - {1'b0, b}; o = t[5:0]; cy = t[6]; end
            4'd7: o = 6'($signed(a) >>> b);
            4'd8: o = ($signed(a) < $signed(b)) ? 6'd1 : 6'd0;
            default: o = 6'd0;
        endcase
        z = (o == 6'd0);
    endfunction

    always_comb begin
        alu_out   = 6'd0;
        alu_carry = 1'b0;
        alu_zero  = 1'b0;
        alu_fn(alu_ctrl, alu_a, alu_b, alu_out, alu_carry, alu_zero);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_result();
        cmd_s       e;
        logic [5:0] ea, eo;
        logic       ec, ez;
        if (q.size() == 0) begin
            chk("res_spurious", 32'(res_valid), 32'd0);
            return;
        end
        e  = q.pop_front();
        ea = e.f ? macc : e.a;
        alu_fn(e.c, ea, e.b, eo, ec, ez);
        macc = eo;
        chk("res_data", 32'(res_data), 32'(eo));
        chk("res_carry", 32'(res_carry), 32'(ec));
        chk("res_zero", 32'(res_zero), 32'(ez));
        chk("res_illegal", 32'(res_illegal), 32'(e.c > 4'd8));
        chk("acc", 32'(acc), 32'(eo));
    endtask

    // Starts and ends at a falling edge; samples 1 time unit after driving.
    task automatic step(input logic v, input logic [3:0] c, input logic [5:0] a,
                        input logic [5:0] b, input logic f, input logic rr);
        cmd_s e;
        cmd_valid = v;
        cmd_ctrl  = c;
        cmd_a     = a;
        cmd_b     = b;
        cmd_fwd   = f;
        res_ready = rr;
        #1;
        if (res_valid && res_ready) check_result();
        if (cmd_valid && cmd_ready) begin
            e.c = c; e.a = a; e.b = b; e.f = f;
            q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic rr);
        step(1'b0, 4'd0, 6'd0, 6'd0, 1'b0, rr);
    endtask

    initial begin
        macc      = 6'd0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_ctrl  = 4'd0;
        cmd_a     = 6'd0;
        cmd_b     = 6'd0;
        cmd_fwd   = 1'b0;
        res_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        chk("rst_acc", 32'(acc), 32'd0);
        chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD 5+3: result visible the cycle after the head is issued
        step(1'b1, 4'd2, 6'd5, 6'd3, 1'b0, 1'b1);
        chk("add_head_a", 32'(alu_a), 32'd5);
        chk("add_not_yet", 32'(res_valid), 32'd0);
        idle(1'b1);
        chk("add_valid", 32'(res_valid), 32'd1);
        chk("add_data", 32'(res_data), 32'd8);
        chk("add_acc", 32'(acc), 32'd8);
        idle(1'b1);

        // SUB 3-5 then forwarded ADD +2
        step(1'b1, 4'd6, 6'd3, 6'd5, 1'b0, 1'b1);
        step(1'b1, 4'd2, 6'd0, 6'd2, 1'b1, 1'b1);
        chk("sub_data", 32'(res_data), 32'd62);
        chk("sub_carry", 32'(res_carry), 32'd1);
        idle(1'b1);
        chk("fwd_data", 32'(res_data), 32'd0);
        chk("fwd_carry", 32'(res_carry), 32'd1);
        chk("fwd_zero", 32'(res_zero), 32'd1);
        idle(1'b1);
        idle(1'b1);

        // Backpressure: one captured plus DEPTH queued
        for (int k = 0; k < 5; k++) begin
            if (k > 0) chk("bp_ready", 32'(cmd_ready), 32'd1);
            step(1'b1, 4'(k % 9), 6'(k + 10), 6'(k + 1), 1'b0, 1'b0);
        end
        chk("bp_full", 32'(cmd_ready), 32'd0);
        step(1'b1, 4'd2, 6'd1, 6'd1, 1'b0, 1'b0);
        chk("bp_q", 32'(q.size()), 32'd5);
        for (int k = 0; k < 5; k++) begin
            chk("bp_drain_valid", 32'(res_valid), 32'd1);
            idle(1'b1);
        end
        chk("bp_empty", 32'(res_valid), 32'd0);

        // Streaming: push and pop every cycle
        for (int k = 0; k < 20; k++) begin
            chk("stream_ready", 32'(cmd_ready), 32'd1);
            step(1'b1, 4'($urandom_range(0, 8)), 6'($urandom),
                 6'($urandom), 1'($urandom), 1'b1);
        end
        idle(1'b1);
        idle(1'b1);

        // Illegal code passes through and is flagged
        step(1'b1, 4'hF, 6'd7, 6'd7, 1'b0, 1'b1);
        idle(1'b1);
        chk("ill_flag", 32'(res_illegal), 32'd1);
        chk("ill_zero", 32'(res_zero), 32'd1);
        chk("ill_data", 32'(res_data), 32'd0);
        step(1'b1, 4'd1, 6'd4, 6'd1, 1'b0, 1'b1);
        idle(1'b1);
        chk("ill_clear", 32'(res_illegal), 32'd0);
        idle(1'b1);

        // Random traffic with random backpressure
        for (int k = 0; k < 300; k++) begin
            step(1'($urandom), 4'($urandom), 6'($urandom), 6'($urandom),
                 1'($urandom), 1'($urandom));
        end
        for (int k = 0; k < 8; k++) idle(1'b1);
        chk("rand_drained", 32'(q.size()), 32'd0);

        // Asynchronous reset with work pending
        for (int k = 0; k < 4; k++)
            step(1'b1, 4'd2, 6'(k), 6'd1, 1'b0, 1'b0);
        chk("pre_rst_valid", 32'(res_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(res_valid), 32'd0);
        chk("arst_ready", 32'(cmd_ready), 32'd1);
        chk("arst_acc", 32'(acc), 32'd0);
        chk("arst_data", 32'(res_data), 32'd0);
        chk("arst_alu_b", 32'(alu_b), 32'd0);
        q.delete();
        macc = 6'd0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            idle(1'b1);
            chk("post_rst_valid", 32'(res_valid), 32'd0);
        end
        step(1'b1, 4'd2, 6'd1, 6'd1, 1'b1, 1'b1);
        idle(1'b1);
        chk("post_rst_fwd", 32'(res_data), 32'd1);
        idle(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
